// File: rtl/rmii_rx_framer_if.sv
// Signal bundle between an RMII PHY-side source and the receive framer.
// The master modport is the framer side. The slave modport is the PHY/consumer side.
interface rmii_rx_framer_if;
    logic        enable;
    logic        phy_rmii_crs;
    logic [1:0]  phy_rmii_rx_data;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic [10:0] rx_len;
    logic        rx_crc_ok;
    logic [2:0]  rx_err;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    modport master (
        input  enable, phy_rmii_crs, phy_rmii_rx_data,
        output rx_data, rx_valid, rx_sof, rx_eof, rx_len, rx_crc_ok, rx_err,
               good_cnt, bad_cnt
    );
    modport slave (
        output enable, phy_rmii_crs, phy_rmii_rx_data,
        input  rx_data, rx_valid, rx_sof, rx_eof, rx_len, rx_crc_ok, rx_err,
               good_cnt, bad_cnt
    );
endinterface

// File: rtl/rmii_rx_framer.sv
// RMII receive framer. It detects the SFD, packs dibits into bytes LSB-first, and checks the FCS.
// It also flags long, short and misaligned frames and keeps saturating good/bad frame counters.
module rmii_rx_framer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic             phy_rmii_clk,
    input  logic             sys_rst_n,
    rmii_rx_framer_if.master bus
);
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t      state;
    logic [5:0]  sh;
    logic [1:0]  phase;
    logic [7:0]  buf_q;
    logic        buf_full;
    logic        sof_pend;
    logic [10:0] len;
    logic [31:0] crc;

    logic [7:0]  byte_new;
    logic        emit_ok;
    logic [2:0]  err_now;
    logic        good_now;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    // len already counts the buffered byte, so it is also that byte's ordinal
    always_comb begin
        byte_new = {bus.phy_rmii_rx_data, sh};
        emit_ok  = buf_full && (len <= MAX_L);
        err_now  = {len > MAX_L, len < MIN_L, phase != 2'd0};
        good_now = (crc == RESIDUE) && (err_now == 3'b000);
    end

    always_ff @(posedge phy_rmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            sh            <= '0;
            phase         <= '0;
            buf_q         <= '0;
            buf_full      <= 1'b0;
            sof_pend      <= 1'b0;
            len           <= '0;
            crc           <= '1;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.rx_sof    <= 1'b0;
            bus.rx_eof    <= 1'b0;
            bus.rx_len    <= '0;
            bus.rx_crc_ok <= 1'b0;
            bus.rx_err    <= '0;
            bus.good_cnt  <= '0;
            bus.bad_cnt   <= '0;
        end else begin
            bus.rx_valid <= 1'b0;
            bus.rx_sof   <= 1'b0;
            bus.rx_eof   <= 1'b0;
            case (state)
                IDLE: begin
                    sh       <= '0;
                    phase    <= '0;
                    buf_full <= 1'b0;
                    sof_pend <= 1'b1;
                    len      <= '0;
                    crc      <= '1;
                    if (bus.phy_rmii_crs)
                        state <= bus.enable ? PREAMBLE : DROP;
                end
                PREAMBLE: begin
                    if (!bus.phy_rmii_crs)                 state <= IDLE;
                    else if (bus.phy_rmii_rx_data == 2'b11) state <= DATA;
                    else if (bus.phy_rmii_rx_data == 2'b10) state <= DROP;
                end
                DATA: begin
                    if (bus.phy_rmii_crs) begin
                        sh    <= byte_new[7:2];
                        phase <= phase + 2'd1;
                        if (phase == 2'd3) begin
                            buf_q    <= byte_new;
                            buf_full <= 1'b1;
                            crc      <= crc_byte(crc, byte_new);
                            if (len != 11'h7FF) len <= len + 11'd1;
                            if (emit_ok) begin
                                bus.rx_valid <= 1'b1;
                                bus.rx_data  <= buf_q;
                                bus.rx_sof   <= sof_pend;
                                sof_pend     <= 1'b0;
                            end
                        end
                    end else begin
                        // Carrier dropped. Flush the held byte and publish the frame status.
                        state         <= IDLE;
                        bus.rx_eof    <= 1'b1;
                        bus.rx_len    <= len;
                        bus.rx_crc_ok <= (crc == RESIDUE);
                        bus.rx_err    <= err_now;
                        if (emit_ok) begin
                            bus.rx_valid <= 1'b1;
                            bus.rx_data  <= buf_q;
                            bus.rx_sof   <= sof_pend;
                        end
                        if (good_now) begin
                            if (bus.good_cnt != 16'hFFFF) bus.good_cnt <= bus.good_cnt + 16'd1;
                        end else begin
                            if (bus.bad_cnt != 16'hFFFF) bus.bad_cnt <= bus.bad_cnt + 16'd1;
                        end
                    end
                end
                DROP: if (!bus.phy_rmii_crs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
